// File: rtl/id_ex_elastic_reg_pkg.sv
// ---------------------------------------------------------------------------
// id_ex_elastic_reg_pkg
// Shared constants and types for the elastic ID->EXE pipeline register.
//   ID_EX_DATA_W : datapath payload width (PC, Val_Rn, Val_Rm, imm24, Dest,
//                  EXE_CMD, src1/src2, shift operand)
//   ID_EX_CTRL_W : control payload width (S, B, MEM_W_EN, MEM_R_EN, WB_EN, imm)
//   ID_EX_CNT_W  : default width of the saturating bubble counter
//   state_e      : occupancy FSM encoding (EMPTY / ONE / FULL)
// ---------------------------------------------------------------------------
package id_ex_elastic_reg_pkg;

  localparam int ID_EX_DATA_W = 148;
  localparam int ID_EX_CTRL_W = 6;
  localparam int ID_EX_CNT_W  = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_e;

endpackage : id_ex_elastic_reg_pkg

// File: rtl/id_ex_elastic_reg_pipe_entry.sv
// ---------------------------------------------------------------------------
// pipe_entry_reg
// One pipeline slot: a payload register with load enable plus a valid bit.
//   clk      : rising-edge clock
//   rst      : asynchronous active-high reset (clears payload and valid)
//   i_load   : capture i_d at the next edge
//   i_d      : payload in
//   i_set    : set valid at the next edge
//   i_clr    : clear valid at the next edge
//   i_kill   : synchronous kill of valid; wins over i_set/i_clr
//   o_q      : held payload
//   o_valid  : slot holds a live entry
// ---------------------------------------------------------------------------
module pipe_entry_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_d,
  input  logic         i_set,
  input  logic         i_clr,
  input  logic         i_kill,
  output logic [W-1:0] o_q,
  output logic         o_valid
);

  logic [W-1:0] r_q;
  logic         r_valid;

  // NOTE: payload is reset too, so out_data reads 0 after reset instead of X;
  // sequential state is only ever written with non-blocking assignments.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q     <= '0;
      r_valid <= 1'b0;
    end else begin
      if (i_load) r_q <= i_d;
      if (i_kill)      r_valid <= 1'b0;
      else if (i_set)  r_valid <= 1'b1;
      else if (i_clr)  r_valid <= 1'b0;
    end
  end

  assign o_q     = r_q;
  assign o_valid = r_valid;

endmodule : pipe_entry_reg

// File: rtl/id_ex_elastic_reg.sv
// ---------------------------------------------------------------------------
// id_ex_elastic_reg
// Elastic ID->EXE pipeline register with a 2-entry skid buffer. The head slot
// (main) drives EXE; the second slot (skid) absorbs one instruction while EXE
// stalls. Control bits are masked on bubbles so EXE sees a NOP. A saturating
// counter records cycles where EXE was ready but starved.
//   clk, rst            : clock, asynchronous active-high reset
//   flush               : drop every held entry at the next edge
//   in_valid/in_ready   : decode-side handshake (in_ready registered)
//   in_data/in_ctrl     : decode-side payload
//   out_valid/out_ready : EXE-side handshake (out_valid registered)
//   out_data/out_ctrl   : head payload (ctrl masked by out_valid)
//   occupancy           : entries held (0..2)
//   bubble_cnt          : starved cycles, saturating
// ---------------------------------------------------------------------------
module id_ex_elastic_reg
  import id_ex_elastic_reg_pkg::*;
#(
  parameter int DATA_W = ID_EX_DATA_W,
  parameter int CTRL_W = ID_EX_CTRL_W,
  parameter int CNT_W  = ID_EX_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  bubble_cnt
);

  localparam int PW = DATA_W + CTRL_W;

  state_e           r_state;
  state_e           w_next_state;
  logic [CNT_W-1:0] r_bubble_cnt;

  logic          w_in_fire;
  logic          w_out_fire;
  logic [PW-1:0] w_in_payload;
  logic [PW-1:0] w_main_d;
  logic [PW-1:0] w_main_q;
  logic [PW-1:0] w_skid_q;
  logic          w_main_valid;
  logic          w_skid_valid;

  logic w_main_load;
  logic w_main_sel_skid;
  logic w_main_set;
  logic w_main_clr;
  logic w_skid_load;
  logic w_skid_set;
  logic w_skid_clr;

  // Handshake flags come straight from flops: no out_ready -> in_ready path.
  assign in_ready   = ~w_skid_valid;
  assign out_valid  = w_main_valid;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = w_main_valid & out_ready;

  assign w_in_payload = {in_ctrl, in_data};
  // Refill from skid when draining FULL, otherwise take the decode payload.
  assign w_main_d     = w_main_sel_skid ? w_skid_q : w_in_payload;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_EMPTY;
    else     r_state <= w_next_state;
  end

  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch can be inferred.
  always_comb begin
    w_next_state    = r_state;
    w_main_load     = 1'b0;
    w_main_sel_skid = 1'b0;
    w_main_set      = 1'b0;
    w_main_clr      = 1'b0;
    w_skid_load     = 1'b0;
    w_skid_set      = 1'b0;
    w_skid_clr      = 1'b0;

    if (flush) begin
      // Valids are killed inside the slots; any in_fire this cycle is lost.
      w_next_state = ST_EMPTY;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_main_load  = 1'b1;
            w_main_set   = 1'b1;
            w_next_state = ST_ONE;
          end
        end
        ST_ONE: begin
          if (w_in_fire && !w_out_fire) begin
            w_skid_load  = 1'b1;
            w_skid_set   = 1'b1;
            w_next_state = ST_FULL;
          end else if (w_out_fire && !w_in_fire) begin
            w_main_clr   = 1'b1;
            w_next_state = ST_EMPTY;
          end else if (w_in_fire && w_out_fire) begin
            w_main_load  = 1'b1;
          end
        end
        ST_FULL: begin
          if (w_out_fire) begin
            w_main_load     = 1'b1;
            w_main_sel_skid = 1'b1;
            w_skid_clr      = 1'b1;
            w_next_state    = ST_ONE;
          end
        end
        default: w_next_state = ST_EMPTY;
      endcase
    end
  end

  pipe_entry_reg #(.W(PW)) u_main (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_main_load),
    .i_d     (w_main_d),
    .i_set   (w_main_set),
    .i_clr   (w_main_clr),
    .i_kill  (flush),
    .o_q     (w_main_q),
    .o_valid (w_main_valid)
  );

  pipe_entry_reg #(.W(PW)) u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_skid_load),
    .i_d     (w_in_payload),
    .i_set   (w_skid_set),
    .i_clr   (w_skid_clr),
    .i_kill  (flush),
    .o_q     (w_skid_q),
    .o_valid (w_skid_valid)
  );

  assign out_data = w_main_q[DATA_W-1:0];
  assign out_ctrl = w_main_q[PW-1:DATA_W] & {CTRL_W{w_main_valid}};

  always_comb begin
    occupancy = 2'd0;
    unique case (r_state)
      ST_ONE:  occupancy = 2'd1;
      ST_FULL: occupancy = 2'd2;
      default: occupancy = 2'd0;
    endcase
  end

  // Starved cycle: EXE ready, nothing to give it. Flush cycles count too.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_bubble_cnt <= '0;
    end else if (out_ready && !w_main_valid && (r_bubble_cnt != {CNT_W{1'b1}})) begin
      r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end
  end

  assign bubble_cnt = r_bubble_cnt;

endmodule : id_ex_elastic_reg

// File: tb/tb_id_ex_elastic_reg.sv
// ---------------------------------------------------------------------------
// tb_id_ex_elastic_reg
// Bench for id_ex_elastic_reg (CNT_W=4 so saturation is reachable). The
// reference model is a FIFO queue of at most two entries plus an integer
// bubble counter; outputs are compared every cycle on the falling edge.
// ---------------------------------------------------------------------------
module tb_id_ex_elastic_reg;

  localparam int DW  = 148;
  localparam int CW  = 6;
  localparam int NW  = 4;
  localparam int SAT = (1 << NW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
  logic [1:0]    occupancy;
  logic [NW-1:0] bubble_cnt;

  always #5 clk = ~clk;

  id_ex_elastic_reg #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(NW)) dut (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_ctrl    (in_ctrl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_ctrl   (out_ctrl),
    .occupancy  (occupancy),
    .bubble_cnt (bubble_cnt)
  );

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } item_t;

  item_t q[$];
  int    m_cnt;
  int    n_delivered;
  int    n_tests;
  int    n_fail;

  task automatic check(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] v;
    v = '0;
    for (int k = 0; k < 5; k++) v = {v[DW-33:0], 32'($urandom)};
    return v;
  endfunction

  task automatic check_outputs();
    logic [CW-1:0] exp_ctrl;
    exp_ctrl = (q.size() > 0) ? q[0].c : '0;
    check("occupancy", DW'(occupancy), DW'(q.size()));
    check("in_ready", DW'(in_ready), DW'(q.size() < 2));
    check("out_valid", DW'(out_valid), DW'(q.size() > 0));
    if (q.size() > 0) check("out_data", out_data, q[0].d);
    check("out_ctrl", DW'(out_ctrl), DW'(exp_ctrl));
    check("bubble_cnt", DW'(bubble_cnt), DW'(m_cnt));
  endtask

  // One clock: check at negedge, advance the model at the rising edge.
  task automatic cycle();
    bit    inf, outf;
    item_t it;
    item_t tmp;
    @(negedge clk);
    check_outputs();
    inf  = in_valid && (q.size() < 2);
    outf = out_ready && (q.size() > 0);
    it.c = in_ctrl;
    it.d = in_data;
    if (out_ready && q.size() == 0 && m_cnt < SAT) m_cnt++;
    @(posedge clk);
    if (outf) n_delivered++;
    if (flush) begin
      q.delete();
    end else begin
      if (outf) tmp = q.pop_front();
      if (inf)  q.push_back(it);
    end
    #1;
  endtask

  task automatic idle_inputs();
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    in_ctrl   = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    q.delete();
    m_cnt       = 0;
    n_delivered = 0;
    @(posedge clk);
    #1;
    check_outputs();
    check("reset out_data", out_data, '0);
    rst = 1'b0;
  endtask

  task automatic push(input logic [DW-1:0] d);
    in_valid = 1'b1;
    in_data  = d;
    in_ctrl  = CW'($urandom);
    cycle();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst     = 1'b1;
    idle_inputs();
    #2;

    // 1. Reset asserted while FULL clears everything without a clock edge.
    do_reset();
    out_ready = 1'b1;
    cycle();                       // one starved cycle -> counter 1
    out_ready = 1'b0;
    push(rand_data());
    push(rand_data());
    push(rand_data());             // held at input: FULL
    check("full before rst", DW'(occupancy), DW'(2));
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    q.delete();
    m_cnt = 0;
    check_outputs();
    check("async rst out_valid", DW'(out_valid), '0);
    check("async rst in_ready", DW'(in_ready), DW'(1));
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle_inputs();

    // 2. Streaming 1..8 with EXE always ready.
    do_reset();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) push(DW'(i));
    in_valid = 1'b0;
    cycle();
    check("stream bubble_cnt", DW'(bubble_cnt), DW'(1));
    check("stream delivered", DW'(n_delivered), DW'(8));

    // 3. Backpressure: A, B accepted, C held; then drain in order.
    do_reset();
    push(DW'(32'hA));
    push(DW'(32'hB));
    push(DW'(32'hC));
    check("bp occupancy", DW'(occupancy), DW'(2));
    check("bp in_ready", DW'(in_ready), '0);
    out_ready = 1'b1;
    cycle();                       // A out, C still held
    cycle();                       // B out, C accepted
    in_valid = 1'b0;
    cycle();                       // C out
    cycle();
    check("bp delivered", DW'(n_delivered), DW'(3));

    // 4. Flush while FULL with a simultaneous in_fire attempt.
    do_reset();
    push(rand_data());
    push(rand_data());
    flush    = 1'b1;
    in_valid = 1'b1;
    in_data  = rand_data();
    cycle();
    check("flush out_valid", DW'(out_valid), '0);
    check("flush out_ctrl", DW'(out_ctrl), '0);
    check("flush occupancy", DW'(occupancy), '0);
    flush    = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    cycle();
    cycle();
    check("flush nothing delivered", DW'(n_delivered), '0);

    // 5. Flush coinciding with out_fire: that entry delivered exactly once.
    do_reset();
    push(rand_data());
    in_valid  = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b1;
    cycle();
    flush = 1'b0;
    check("flush+fire occupancy", DW'(occupancy), '0);
    cycle();
    cycle();
    check("flush+fire delivered once", DW'(n_delivered), DW'(1));

    // 6. Counter saturation.
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) cycle();
    check("bubble saturated", DW'(bubble_cnt), DW'(SAT));

    // Random traffic against the queue model.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      in_valid  = ($urandom_range(0, 99) < 55);
      out_ready = ($urandom_range(0, 99) < 60);
      flush     = ($urandom_range(0, 99) < 4);
      in_data   = rand_data();
      in_ctrl   = CW'($urandom);
      cycle();
    end
    idle_inputs();
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_id_ex_elastic_reg
